// File: rtl/alu_pipe_if.sv
// Handshaked operand/result bundle for alu_pipe.
// The producer/consumer holds the master side and the ALU holds the slave side.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ZF;
  logic             CF;
  logic             OF;
  logic             SF;
  logic             ILL;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, ZF, CF, OF, SF, ILL
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, ZF, CF, OF, SF, ILL
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined RV32 ALU: registered result stage, valid/ready flow control and an
// iterative shift-add multiplier for MUL/MULHU.
module alu_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned M  = WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic             accept, is_mul, mul_last;
  logic             in_ready_c, out_valid_c;
  logic [SW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_nxt;
  logic [WIDTH:0]   psum;
  logic             hi_sel_q;
  logic [WIDTH-1:0] mul_r;
  logic             mul_cf;

  logic [WIDTH-1:0] out_q;
  logic             zf_q, cf_q, of_q, sf_q, ill_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_r;
  logic             alu_cf, alu_of, alu_ill;

  assign is_mul   = MUL_EN && ((bus.op == 4'b1001) || (bus.op == 4'b1010));
  assign accept   = bus.in_valid & in_ready_c;
  assign mul_last = (cnt_q == SW'(WIDTH - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.in_valid) state_d = is_mul ? StBusy : StDone;
      StBusy: if (mul_last) state_d = StDone;
      StDone: begin
        if (bus.out_ready) begin
          if (!bus.in_valid) state_d = StIdle;
          else               state_d = is_mul ? StBusy : StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // in_ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      StIdle: in_ready_c = rst_n;
      StBusy: in_ready_c = 1'b0;
      StDone: begin
        out_valid_c = 1'b1;
        in_ready_c  = rst_n & bus.out_ready;
      end
      default: in_ready_c = 1'b0;
    endcase
  end

  // ---------------- single-cycle ALU ----------------
  assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff  = bus.a - bus.b;
  assign shamt = bus.b[SW-1:0];

  always_comb begin
    alu_r   = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      4'b0000: begin
        alu_r  = sum[WIDTH-1:0];
        alu_cf = sum[WIDTH];
        alu_of = (bus.a[M] == bus.b[M]) && (sum[M] != bus.a[M]);
      end
      4'b0001: alu_r = bus.a << shamt;
      4'b0010: alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b0011: alu_r = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'b0100: alu_r = bus.a ^ bus.b;
      4'b0101: alu_r = bus.a >> shamt;
      4'b0110: alu_r = bus.a | bus.b;
      4'b0111: alu_r = bus.a & bus.b;
      4'b1000: begin
        alu_r  = diff;
        alu_cf = (bus.a < bus.b);
        alu_of = (bus.a[M] != bus.b[M]) && (diff[M] != bus.a[M]);
      end
      4'b1101: alu_r = $signed(bus.a) >>> shamt;
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------- shift-add multiplier ----------------
  // prod_q holds {partial high half, unconsumed multiplier bits}; one bit retires per cycle.
  assign psum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_nxt = {psum, prod_q[WIDTH-1:1]};
  assign mul_r    = hi_sel_q ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
  assign mul_cf   = !hi_sel_q && (prod_nxt[2*WIDTH-1:WIDTH] != '0);

  // ---------------- result stage ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      sf_q     <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      hi_sel_q <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand_q  <= bus.a;
        prod_q   <= {{WIDTH{1'b0}}, bus.b};
        hi_sel_q <= bus.op[1];
        cnt_q    <= '0;
      end else begin
        out_q <= alu_r;
        zf_q  <= !alu_ill && (alu_r == '0);
        sf_q  <= alu_r[M];
        cf_q  <= alu_cf;
        of_q  <= alu_of;
        ill_q <= alu_ill;
      end
    end else if (state_q == StBusy) begin
      prod_q <= prod_nxt;
      cnt_q  <= cnt_q + SW'(1);
      if (mul_last) begin
        out_q <= mul_r;
        zf_q  <= (mul_r == '0);
        sf_q  <= mul_r[M];
        cf_q  <= mul_cf;
        of_q  <= mul_cf;
        ill_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out       = out_q;
  assign bus.ZF        = zf_q;
  assign bus.CF        = cf_q;
  assign bus.OF        = of_q;
  assign bus.SF        = sf_q;
  assign bus.ILL       = ill_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: 32-bit, 16-bit and 32-bit MUL_EN=0 instances, directed vectors.
module tb_alu_pipe;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SLL = 4'b0001, OP_SLT = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011, OP_XOR = 4'b0100, OP_SRL = 4'b0101;
  localparam logic [3:0] OP_OR = 4'b0110, OP_AND = 4'b0111, OP_SUB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001, OP_MULHU = 4'b1010, OP_SRA = 4'b1101;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic [4:0]  fl;   // {ZF, CF, OF, SF, ILL}
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   last_waits;

  logic        dv[3];
  logic [31:0] da[3];
  logic [31:0] db[3];
  logic [3:0]  dop[3];
  logic        drdy[3];
  logic        mv[3];
  logic        mrdy[3];
  logic [31:0] mout[3];
  logic [4:0]  mfl[3];

  exp_t sbq[3][$];
  bit   seen[3];
  exp_t e;

  alu_pipe_if #(.WIDTH(32)) if32 ();
  alu_pipe_if #(.WIDTH(16)) if16 ();
  alu_pipe_if #(.WIDTH(32)) ifnm ();

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) dutnm (.clk(clk), .rst_n(rst_n), .bus(ifnm));

  assign if32.in_valid = dv[0];
  assign if32.a = da[0];
  assign if32.b = db[0];
  assign if32.op = dop[0];
  assign if32.out_ready = drdy[0];
  assign if16.in_valid = dv[1];
  assign if16.a = da[1][15:0];
  assign if16.b = db[1][15:0];
  assign if16.op = dop[1];
  assign if16.out_ready = drdy[1];
  assign ifnm.in_valid = dv[2];
  assign ifnm.a = da[2];
  assign ifnm.b = db[2];
  assign ifnm.op = dop[2];
  assign ifnm.out_ready = drdy[2];

  assign mv[0] = if32.out_valid;
  assign mv[1] = if16.out_valid;
  assign mv[2] = ifnm.out_valid;
  assign mrdy[0] = if32.in_ready;
  assign mrdy[1] = if16.in_ready;
  assign mrdy[2] = ifnm.in_ready;
  assign mout[0] = if32.out;
  assign mout[1] = {16'h0, if16.out};
  assign mout[2] = ifnm.out;
  assign mfl[0] = {if32.ZF, if32.CF, if32.OF, if32.SF, if32.ILL};
  assign mfl[1] = {if16.ZF, if16.CF, if16.OF, if16.SF, if16.ILL};
  assign mfl[2] = {ifnm.ZF, ifnm.CF, ifnm.OF, ifnm.SF, ifnm.ILL};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int k, input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic [4:0] ef, input int lat);
    exp_t x;
    dv[k] = 1'b1;
    dop[k] = op;
    da[k] = a;
    db[k] = b;
    last_waits = 0;
    forever begin
      @(negedge clk);
      if (mrdy[k]) break;
      last_waits++;
      if (last_waits > 100) begin
        chk({tag, "/accept_timeout"}, 32'(mrdy[k]), 32'd1);
        dv[k] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    x.tag = tag;
    x.out = eo;
    x.fl = ef;
    x.lat = lat;
    x.acc = cyc;
    sbq[k].push_back(x);
    @(posedge clk);
    #1;
    // Scramble the inputs after accept: captured operands must not change.
    dv[k] = 1'b0;
    da[k] = ~a;
    db[k] = ~b;
    dop[k] = ~op;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (mv[k]) begin
          if (sbq[k].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out[%0d]: got out=%h valid, want no result", k, mout[k]);
          end else begin
            e = sbq[k][0];
            chk({e.tag, "/out"}, mout[k], e.out);
            chk({e.tag, "/flags"}, 32'(mfl[k]), 32'(e.fl));
            if (!seen[k]) chk({e.tag, "/latency"}, cyc - e.acc, e.lat);
            seen[k] = 1'b1;
            if (drdy[k]) begin
              void'(sbq[k].pop_front());
              seen[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      dv[k] = 1'b0;
      da[k] = '0;
      db[k] = '0;
      dop[k] = '0;
      drdy[k] = 1'b1;
      seen[k] = 1'b0;
    end
    #3;
    chk("reset/in_ready", 32'(mrdy[0]), 32'd0);
    chk("reset/out_valid", 32'(mv[0]), 32'd0);
    chk("reset/out", mout[0], 32'd0);
    chk("reset/flags", 32'(mfl[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle/in_ready", 32'(mrdy[0]), 32'd1);
    @(posedge clk);
    #1;

    // 32-bit single-cycle ops
    issue(0, "add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b11000, 1);
    issue(0, "add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b00110, 1);
    issue(0, "sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 5'b00100, 1);
    issue(0, "sub_borrow", OP_SUB, 32'h1, 32'h2, 32'hFFFF_FFFF, 5'b01010, 1);
    issue(0, "sra", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 5'b00010, 1);
    issue(0, "srl", OP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 5'b00000, 1);
    issue(0, "sll", OP_SLL, 32'h1, 32'h3F, 32'h8000_0000, 5'b00010, 1);
    issue(0, "slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000, 1);
    issue(0, "sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b10000, 1);
    issue(0, "xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 5'b00010, 1);
    issue(0, "or", OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 5'b00000, 1);
    issue(0, "and", OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 5'b10000, 1);
    issue(0, "ill_1111", 4'b1111, 32'h1234, 32'h5678, 32'h0, 5'b00001, 1);
    issue(0, "ill_1011", 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00001, 1);
    drain();

    // Multiply: in_ready must stay low across the whole iteration.
    issue(0, "mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 5'b11100, 33);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul/busy_in_ready", 32'(mrdy[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(0, "mulhu", OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1, 5'b00000, 33);
    issue(0, "mul_odd", OP_MUL, 32'h0000_0007, 32'h0000_0006, 32'd42, 5'b00000, 33);
    drain();

    // Backpressure, then same-cycle handoff with no bubble.
    drdy[0] = 1'b0;
    issue(0, "bp_hold", OP_ADD, 32'd5, 32'd7, 32'd12, 5'b00000, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    drdy[0] = 1'b1;
    issue(0, "bp_next", OP_ADD, 32'd3, 32'd4, 32'd7, 5'b00000, 1);
    chk("bp_next/accept_waits", last_waits, 0);
    drain();

    // MUL_EN=0 instance
    issue(2, "nm_mul_ill", OP_MUL, 32'd3, 32'd4, 32'h0, 5'b00001, 1);
    issue(2, "nm_mulhu_ill", OP_MULHU, 32'd3, 32'd4, 32'h0, 5'b00001, 1);
    issue(2, "nm_add", OP_ADD, 32'd2, 32'd3, 32'd5, 5'b00000, 1);
    drain();

    // WIDTH=16 instance
    issue(1, "w16_add", OP_ADD, 32'hFFFF, 32'h1, 32'h0, 5'b11000, 1);
    issue(1, "w16_sub_ovf", OP_SUB, 32'h8000, 32'h1, 32'h7FFF, 5'b00100, 1);
    issue(1, "w16_sub_borrow", OP_SUB, 32'h1, 32'h2, 32'hFFFF, 5'b01010, 1);
    issue(1, "w16_sra", OP_SRA, 32'h8000, 32'h14, 32'hF800, 5'b00010, 1);
    issue(1, "w16_srl", OP_SRL, 32'h8000, 32'h14, 32'h0800, 5'b00000, 1);
    issue(1, "w16_slt", OP_SLT, 32'hFFFF, 32'h1, 32'h1, 5'b00000, 1);
    issue(1, "w16_sltu", OP_SLTU, 32'hFFFF, 32'h1, 32'h0, 5'b10000, 1);
    issue(1, "w16_mul", OP_MUL, 32'h0100, 32'h0100, 32'h0, 5'b11100, 17);
    issue(1, "w16_mulhu", OP_MULHU, 32'h0100, 32'h0100, 32'h1, 5'b00000, 17);
    issue(1, "w16_ill", 4'b1111, 32'h1, 32'h1, 32'h0, 5'b00001, 1);
    drain();

    // Reset in the middle of a multiply: result is dropped, outputs clear at once.
    issue(0, "sticky", OP_OR, 32'h0000_00AB, 32'h0, 32'h0000_00AB, 5'b00000, 1);
    issue(0, "mul_reset", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 5'b11100, 33);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    sbq[0].delete();
    seen[0] = 1'b0;
    chk("midreset/out", mout[0], 32'd0);
    chk("midreset/flags", 32'(mfl[0]), 32'd0);
    chk("midreset/out_valid", 32'(mv[0]), 32'd0);
    chk("midreset/in_ready", 32'(mrdy[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("postreset/out_valid", 32'(mv[0]), 32'd0);
    chk("postreset/out", mout[0], 32'd0);
    issue(0, "postreset_add", OP_ADD, 32'd10, 32'd20, 32'd30, 5'b00000, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
